// File: rtl/band_meter_pkg.sv
// Shared constants, types and helpers for the band_meter spectrum-bar ballistics block.
package band_meter_pkg;

   localparam int NUM_BANDS  = 7;
   localparam int LEVEL_W    = 8;
   localparam int BAND_IDX_W = 3;

   typedef logic [BAND_IDX_W-1:0] band_idx_t;
   typedef logic [LEVEL_W-1:0]    level_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_t;

   localparam band_idx_t LAST_IDX = band_idx_t'(NUM_BANDS - 1);

   // Subtract one extra bit wide so an underflow shows up as a borrow and clamps to zero.
   function automatic level_t sat_sub(input level_t a, input level_t b);
      logic [LEVEL_W:0] diff;
      diff = {1'b0, a} - {1'b0, b};
      if (diff[LEVEL_W]) begin
         return {LEVEL_W{1'b0}};
      end else begin
         return diff[LEVEL_W-1:0];
      end
   endfunction

endpackage

// File: rtl/band_tracker.sv
// One band's attack/hold/decay ballistics; peak-dot logic only with BAND_METER_PEAK_DOT_EN.
module band_tracker
   import band_meter_pkg::*;
#(
   parameter int DECAY_STEP = 4,
   parameter int HOLD_TICKS = 50
`ifdef BAND_METER_PEAK_DOT_EN
  ,parameter int PEAK_HOLD_TICKS = 100
`endif
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               ready,
   input  logic               decay_tick,
   input  logic [LEVEL_W-1:0] freq,
   output logic [LEVEL_W-1:0] level,
   output logic [LEVEL_W-1:0] peak
);

   localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

   level_t             level_q, level_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;

   // Level/hold next state: attack beats a coincident decay tick.
   always_comb begin
      level_d = level_q;
      hold_d  = hold_q;
      if (ready) begin
         if (freq >= level_q) begin
            level_d = freq;
            hold_d  = HOLD_W'(HOLD_TICKS);
         end else if (decay_tick && (hold_q != {HOLD_W{1'b0}})) begin
            hold_d  = hold_q - HOLD_W'(1);
         end else if (decay_tick) begin
            level_d = sat_sub(level_q, LEVEL_W'(DECAY_STEP));
         end else begin
            level_d = level_q;
            hold_d  = hold_q;
         end
      end else begin
         level_d = level_q;
         hold_d  = hold_q;
      end
   end

   // Level/hold state registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         level_q <= {LEVEL_W{1'b0}};
         hold_q  <= {HOLD_W{1'b0}};
      end else begin
         level_q <= level_d;
         hold_q  <= hold_d;
      end
   end

   assign level = level_q;

`ifdef BAND_METER_PEAK_DOT_EN
   localparam int PCNT_W = (PEAK_HOLD_TICKS > 0) ? $clog2(PEAK_HOLD_TICKS + 1) : 1;

   level_t             peak_q, peak_d;
   logic [PCNT_W-1:0]  peak_cnt_q, peak_cnt_d;

   // Peak dot falls straight onto the freshly updated level once its hold expires.
   always_comb begin
      peak_d     = peak_q;
      peak_cnt_d = peak_cnt_q;
      if (ready && (freq >= peak_q)) begin
         peak_d     = freq;
         peak_cnt_d = PCNT_W'(PEAK_HOLD_TICKS);
      end else if (decay_tick && (peak_cnt_q != {PCNT_W{1'b0}})) begin
         peak_cnt_d = peak_cnt_q - PCNT_W'(1);
      end else if (decay_tick) begin
         peak_d     = level_d;
      end else begin
         peak_d     = peak_q;
         peak_cnt_d = peak_cnt_q;
      end
   end

   // Peak state registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         peak_q     <= {LEVEL_W{1'b0}};
         peak_cnt_q <= {PCNT_W{1'b0}};
      end else begin
         peak_q     <= peak_d;
         peak_cnt_q <= peak_cnt_d;
      end
   end

   assign peak = peak_q;
`else
   assign peak = level_q;
`endif

endmodule

// File: rtl/band_meter.sv
// Seven-band meter ballistics plus a 7-beat serial scan per sample for the bar renderer.
// Optional peak dots are enabled by defining BAND_METER_PEAK_DOT_EN.
module band_meter
   import band_meter_pkg::*;
#(
   parameter int DECAY_DIV       = 480,
   parameter int DECAY_STEP      = 4,
   parameter int HOLD_TICKS      = 50,
   parameter int PEAK_HOLD_TICKS = 100
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  ready,
   input  logic [LEVEL_W-1:0]    freq1,
   input  logic [LEVEL_W-1:0]    freq2,
   input  logic [LEVEL_W-1:0]    freq3,
   input  logic [LEVEL_W-1:0]    freq4,
   input  logic [LEVEL_W-1:0]    freq5,
   input  logic [LEVEL_W-1:0]    freq6,
   input  logic [LEVEL_W-1:0]    freq7,
   output logic                  band_valid,
   output logic [BAND_IDX_W-1:0] band_sel,
   output logic [LEVEL_W-1:0]    band_level,
   output logic [LEVEL_W-1:0]    peak_level,
   output logic                  frame_done
);

   localparam int PRE_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam int SLOTS = 2 ** BAND_IDX_W;
   // A nonsensical configuration freezes decay instead of producing garbage ballistics.
   localparam bit CFG_OK = (DECAY_DIV >= 1) && (DECAY_STEP >= 0) && (HOLD_TICKS >= 0)
                           && (PEAK_HOLD_TICKS >= 0);

   level_t              freq_s  [NUM_BANDS];
   level_t              level_s [SLOTS];
   level_t              peak_s  [SLOTS];

   logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
   logic                pre_last_s;
   logic                decay_tick_s;

   scan_state_t         state_q;
   band_idx_t           idx_q;
   logic                pending_q;
   logic                band_valid_q;
   band_idx_t           band_sel_q;
   level_t              band_level_q;
   level_t              peak_level_q;
   logic                frame_done_q;

   assign freq_s[0] = freq1;
   assign freq_s[1] = freq2;
   assign freq_s[2] = freq3;
   assign freq_s[3] = freq4;
   assign freq_s[4] = freq5;
   assign freq_s[5] = freq6;
   assign freq_s[6] = freq7;

   assign pre_last_s   = (pre_cnt_q == PRE_W'(DECAY_DIV - 1));
   assign decay_tick_s = CFG_OK && ready && pre_last_s;

   // Decay prescaler next state: counts ready strobes only.
   always_comb begin
      pre_cnt_d = pre_cnt_q;
      if (ready) begin
         if (pre_last_s) begin
            pre_cnt_d = {PRE_W{1'b0}};
         end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
         end
      end else begin
         pre_cnt_d = pre_cnt_q;
      end
   end

   // Decay prescaler register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pre_cnt_q <= {PRE_W{1'b0}};
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

   // Unused index slots read as zero so the scan mux never indexes out of range.
   for (genvar b = 0; b < SLOTS; b++) begin : g_band
      if (b < NUM_BANDS) begin : g_trk
         band_tracker #(
            .DECAY_STEP      (DECAY_STEP),
            .HOLD_TICKS      (HOLD_TICKS)
`ifdef BAND_METER_PEAK_DOT_EN
           ,.PEAK_HOLD_TICKS (PEAK_HOLD_TICKS)
`endif
         ) u_trk (
            .clock      (clock),
            .reset_n    (reset_n),
            .ready      (ready),
            .decay_tick (decay_tick_s),
            .freq       (freq_s[b]),
            .level      (level_s[b]),
            .peak       (peak_s[b])
         );
      end else begin : g_pad
         assign level_s[b] = {LEVEL_W{1'b0}};
         assign peak_s[b]  = {LEVEL_W{1'b0}};
      end
   end

   // Scan FSM with registered beat outputs; a ready during a scan queues exactly one more scan.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= {BAND_IDX_W{1'b0}};
         pending_q    <= 1'b0;
         band_valid_q <= 1'b0;
         band_sel_q   <= {BAND_IDX_W{1'b0}};
         band_level_q <= {LEVEL_W{1'b0}};
         peak_level_q <= {LEVEL_W{1'b0}};
         frame_done_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               band_valid_q <= 1'b0;
               frame_done_q <= 1'b0;
               pending_q    <= 1'b0;
               if (ready) begin
                  state_q <= ST_SCAN;
                  idx_q   <= {BAND_IDX_W{1'b0}};
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_SCAN: begin
               band_valid_q <= 1'b1;
               band_sel_q   <= idx_q;
               band_level_q <= level_s[idx_q];
               peak_level_q <= peak_s[idx_q];
               if (idx_q == LAST_IDX) begin
                  frame_done_q <= 1'b1;
                  idx_q        <= {BAND_IDX_W{1'b0}};
                  pending_q    <= 1'b0;
                  if (pending_q || ready) begin
                     state_q <= ST_SCAN;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  frame_done_q <= 1'b0;
                  idx_q        <= idx_q + BAND_IDX_W'(1);
                  if (ready) begin
                     pending_q <= 1'b1;
                  end else begin
                     pending_q <= pending_q;
                  end
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               idx_q        <= {BAND_IDX_W{1'b0}};
               pending_q    <= 1'b0;
               band_valid_q <= 1'b0;
               frame_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign band_valid = band_valid_q;
   assign band_sel   = band_sel_q;
   assign band_level = band_level_q;
   assign peak_level = peak_level_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_band_meter.sv
// Directed scoreboard bench for band_meter: a behavioural ballistics model plus a queue of expected beats.
module tb_band_meter;

   localparam int NB        = 7;
   localparam int T_DIV     = 4;
   localparam int T_STEP    = 4;
   localparam int T_HOLD    = 2;
   localparam int T_PK_HOLD = 4;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       ready   = 1'b0;
   logic [7:0] f [NB];
   logic       band_valid;
   logic [2:0] band_sel;
   logic [7:0] band_level;
   logic [7:0] peak_level;
   logic       frame_done;

   typedef struct {
      int sel;
      bit last;
   } beat_t;

   beat_t sbq[$];
   int    m_level [NB];
   int    m_hold  [NB];
   int    m_peak  [NB];
   int    m_pcnt  [NB];
   int    m_pre;
   int    test_cnt = 0;
   int    fail_cnt = 0;

   always #5 clock = ~clock;

   band_meter #(
      .DECAY_DIV       (T_DIV),
      .DECAY_STEP      (T_STEP),
      .HOLD_TICKS      (T_HOLD),
      .PEAK_HOLD_TICKS (T_PK_HOLD)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .ready      (ready),
      .freq1      (f[0]),
      .freq2      (f[1]),
      .freq3      (f[2]),
      .freq4      (f[3]),
      .freq5      (f[4]),
      .freq6      (f[5]),
      .freq7      (f[6]),
      .band_valid (band_valid),
      .band_sel   (band_sel),
      .band_level (band_level),
      .peak_level (peak_level),
      .frame_done (frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_pre = 0;
      for (int b = 0; b < NB; b++) begin
         m_level[b] = 0;
         m_hold[b]  = 0;
         m_peak[b]  = 0;
         m_pcnt[b]  = 0;
      end
   endtask

   task automatic model_ready();
      bit tick;
      tick  = (m_pre == T_DIV - 1);
      m_pre = tick ? 0 : m_pre + 1;
      for (int b = 0; b < NB; b++) begin
         if (int'(f[b]) >= m_level[b]) begin
            m_level[b] = int'(f[b]);
            m_hold[b]  = T_HOLD;
         end else if (tick && m_hold[b] != 0) begin
            m_hold[b]--;
         end else if (tick) begin
            m_level[b] = (m_level[b] >= T_STEP) ? m_level[b] - T_STEP : 0;
         end
         if (int'(f[b]) >= m_peak[b]) begin
            m_peak[b] = int'(f[b]);
            m_pcnt[b] = T_PK_HOLD;
         end else if (tick && m_pcnt[b] != 0) begin
            m_pcnt[b]--;
         end else if (tick) begin
            m_peak[b] = m_level[b];
         end
      end
   endtask

   function automatic int exp_peak(input int sel);
`ifdef BAND_METER_PEAK_DOT_EN
      return m_peak[sel];
`else
      return m_level[sel];
`endif
   endfunction

   // One clock: drive inputs, sample #1 after the edge, compare, then advance the model.
   task automatic cycle(input bit rdy, input bit rst);
      beat_t b;
      ready   = rdy;
      reset_n = !rst;
      @(posedge clock);
      #1;
      if (rst) begin
         chk("rst_valid", band_valid, 0);
         chk("rst_sel",   band_sel,   0);
         chk("rst_level", band_level, 0);
         chk("rst_peak",  peak_level, 0);
         chk("rst_frame", frame_done, 0);
         model_clear();
         sbq.delete();
      end else begin
         if (sbq.size() > 0) begin
            b = sbq.pop_front();
            chk("beat_valid", band_valid, 1);
            chk("beat_sel",   band_sel,   b.sel);
            chk("beat_frame", frame_done, b.last);
            chk("beat_level", band_level, m_level[b.sel]);
            chk("beat_peak",  peak_level, exp_peak(b.sel));
         end else begin
            chk("idle_valid", band_valid, 0);
            chk("idle_frame", frame_done, 0);
         end
         if (rdy) begin
            model_ready();
            if (sbq.size() < NB) begin
               for (int i = 0; i < NB; i++) begin
                  b.sel  = i;
                  b.last = (i == NB - 1);
                  sbq.push_back(b);
               end
            end
         end
      end
   endtask

   task automatic pulse(input int period);
      cycle(1'b1, 1'b0);
      repeat (period - 1) cycle(1'b0, 1'b0);
   endtask

   initial begin
      model_clear();
      for (int b = 0; b < NB; b++) f[b] = 8'd33;

      // Reset held with ready toggling
      for (int i = 0; i < 5; i++) cycle(i[0], 1'b1);
      for (int b = 0; b < NB; b++) f[b] = 8'd0;
      repeat (3) cycle(1'b0, 1'b0);

      // Single attack on band 2
      f[2] = 8'd200;
      pulse(10);
      f[2] = 8'd0;

      // Small level on band 4 to exercise saturation at zero
      f[4] = 8'd3;
      pulse(8);
      f[4] = 8'd0;

      // Hold then linear decay
      repeat (70) pulse(8);

      // Back-to-back scans
      repeat (12) pulse(7);
      repeat (3) cycle(1'b0, 1'b0);

      // Second ready during beat 3 of a scan
      for (int b = 0; b < NB; b++) f[b] = 8'd90;
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      for (int b = 0; b < NB; b++) f[b] = 8'd120 + 8'(b);
      cycle(1'b1, 1'b0);
      repeat (15) cycle(1'b0, 1'b0);

      // Reset in the middle of a scan
      for (int b = 0; b < NB; b++) f[b] = 8'd0;
      f[5] = 8'd77;
      cycle(1'b1, 1'b0);
      repeat (4) cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      f[5] = 8'd0;
      repeat (12) cycle(1'b0, 1'b0);

      // Peak dot on band 0
      f[0] = 8'd150;
      pulse(8);
      f[0] = 8'd0;
      repeat (40) pulse(8);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
